pm1_stim_sequencer: RTL and testbench
=====================================

// Module: pm1_stim_sequencer
// PURPOSE
//  Upstream feeder for the pm1 combinational block. Buffers 16-bit input vectors in a FIFO
//  and drives them onto pm1's pi00..pi15 from a register, one per cycle.
//  Captures the 13 returned po bits one cycle later and presents each result with a
//  sequence tag on a valid/ready interface.
//  Registered pi bus so pm1 sees glitch-free, cycle-aligned stimulus.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >=2
//  TAG_W  8  width of result sequence tag
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      sync: drop FIFO contents and the in-flight vector
//  in_valid   in   1      in_vec valid
//  in_ready   out  1      FIFO can accept (= !full)
//  in_vec     in   16     bit i -> pi{i}
//  pi_bus     out  16     registered drive to pm1 pi00..pi15 (bit i = pi{i})
//  po_bus     in   13     pm1 outputs (bit j = po{j}), combinational from pi_bus
//  out_valid  out  1      out_vec/out_tag valid
//  out_ready  in   1      consumer accepts
//  out_vec    out  13     captured po_bus
//  out_tag    out  TAG_W  sequence number of this result
//  fill       out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, fill=0, in_ready=1, pi_bus=0, s1_v=0,
//  out_valid=0, out_vec=0, out_tag=0, tag counter=0.
//  Pipeline: FIFO -> S1 (pi_bus reg, s1_v) -> pm1 comb -> S2 (out_vec reg, out_valid).
//  - push = in_valid & in_ready. in_ready = (fill != DEPTH); no push-when-full.
//  - s2_adv = s1_v & (!out_valid | out_ready).
//  - pop = (fill != 0) & (!s1_v | s2_adv). On pop: pi_bus <= head, s1_v <= 1.
//    If s2_adv & !pop then s1_v <= 0.
//  - On s2_adv: out_vec <= po_bus, out_tag <= tag_cnt, out_valid <= 1,
//    tag_cnt <= tag_cnt+1 mod 2^TAG_W (wraps 2^TAG_W-1 -> 0).
//  - out_valid & out_ready & !s2_adv: out_valid <= 0. out_vec/out_tag held while
//    out_valid & !out_ready.
//  - pi_bus holds its last value when S1 is empty; it never returns to 0 except on reset.
//  - Latency: pop edge -> out_valid next edge (1 cycle).
//    push -> earliest out_valid: 2 edges (empty FIFO, no bypass).
//  - Throughput: 1 result/cycle with out_ready held high.
//  - Simultaneous push & pop with the FIFO full: in_ready=0, so no push; fill drops by 1.
//  - Simultaneous push & pop otherwise: fill unchanged.
//  - Pointers: log2(DEPTH)-bit, wrap naturally. fill = count register updated +push-pop.
//  - Backpressure: with out_valid=1 & out_ready=0, S1 holds and pi_bus is stable.
//    The FIFO fills, then in_ready=0.
//  - flush (has priority over push/pop that cycle):
//    next edge fill=0, s1_v=0, pi_bus unchanged.
//    S2 and its out_valid unaffected; tag_cnt unaffected.
//  - Reset mid-operation: all state cleared immediately, no partial result emitted.
// TESTING
//  1 Reset then in_vec=0x0000 one beat, out_ready=1 -> pi_bus=0x0000;
//    out_vec=0x1BE, out_tag=0 two edges after push.
//  2 Stream 6 vectors back-to-back, out_ready=1, DEPTH=4 -> in_ready stays 1;
//    6 results with tags 0..5 on consecutive cycles, in input order.
//  3 out_ready=0, push until in_ready=0 -> fill=4, S1 and S2 full.
//    pi_bus stable, out_vec held.
//    Release out_ready -> all 6 drain in order, no loss/duplication.
//  4 flush while fill=3, s1_v=1, out_valid=1 -> next edge fill=0, s1_v=0, in_ready=1.
//    Pending S2 result still delivered; next result tag = that tag+1.
//  5 TAG_W=2, push 5 vectors -> tags 0,1,2,3,0.
//  6 Deassert rst_n mid-stream (async, between edges) -> outputs at reset values
//    immediately; after release, first new result tag=0.

Source files
------------

// File: rtl/pm1_stim_sequencer_if.sv
// Handshake and stimulus bus between the pm1 stimulus sequencer and its environment.
// The master modport is the sequencer: it accepts vectors, drives pi_bus, and returns results.
`timescale 1ns/1ps
interface pm1_stim_sequencer_if #(
  parameter int unsigned TAG_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_vec;
  logic [15:0]      pi_bus;
  logic [12:0]      po_bus;
  logic             out_valid;
  logic             out_ready;
  logic [12:0]      out_vec;
  logic [TAG_W-1:0] out_tag;

  modport master (
    input  in_valid, in_vec, po_bus, out_ready,
    output in_ready, pi_bus, out_valid, out_vec, out_tag
  );

  modport slave (
    output in_valid, in_vec, po_bus, out_ready,
    input  in_ready, pi_bus, out_valid, out_vec, out_tag
  );
endinterface

// File: rtl/pm1_stim_sequencer.sv
// Stimulus feeder for the combinational pm1 block: FIFO -> registered pi_bus (S1) ->
// pm1 -> registered result with sequence tag (S2) on a valid/ready interface.
`timescale 1ns/1ps
module pm1_stim_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  pm1_stim_sequencer_if.master       bus,
  output logic [$clog2(DEPTH):0]     fill
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [15:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             s1_v_q, s1_v_d;
  logic [15:0]      pi_q, pi_d;
  logic             out_valid_q, out_valid_d;
  logic [12:0]      out_vec_q, out_vec_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic in_ready;
  logic push, pop, s2_adv;

  // Handshake decode; flush suppresses every transfer into or out of FIFO/S1 that cycle,
  // which also drops the in-flight S1 vector instead of letting it reach S2.
  always_comb begin
    in_ready = (cnt_q != CntW'(DEPTH));
    push     = bus.in_valid & in_ready & ~flush;
    s2_adv   = s1_v_q & (~out_valid_q | bus.out_ready) & ~flush;
    pop      = (cnt_q != '0) & (~s1_v_q | s2_adv) & ~flush;
  end

  // Next-state for FIFO pointers/count, S1 and S2.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    s1_v_d      = s1_v_q;
    pi_d        = pi_q;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    out_tag_d   = out_tag_q;
    tag_d       = tag_q;

    if (flush) begin
      // pi_bus keeps its value; only occupancy is discarded.
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
      s1_v_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        pi_d     = mem_q[rd_ptr_q];
        s1_v_d   = 1'b1;
      end else if (s2_adv) begin
        s1_v_d = 1'b0;
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    if (s2_adv) begin
      out_vec_d   = bus.po_bus;
      out_tag_d   = tag_q;
      out_valid_d = 1'b1;
      tag_d       = tag_q + TAG_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_vec;
  end

  // Control and pipeline state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      s1_v_q      <= 1'b0;
      pi_q        <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_tag_q   <= '0;
      tag_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      s1_v_q      <= s1_v_d;
      pi_q        <= pi_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      out_tag_q   <= out_tag_d;
      tag_q       <= tag_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.pi_bus    = pi_q;
    bus.out_valid = out_valid_q;
    bus.out_vec   = out_vec_q;
    bus.out_tag   = out_tag_q;
    fill          = cnt_q;
  end
endmodule

// File: tb/tb_pm1_stim_sequencer.sv
// Directed bench for pm1_stim_sequencer; a small stand-in for pm1 maps pi_bus to po_bus.
`timescale 1ns/1ps
module tb_pm1_stim_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       flush2 = 1'b0;
  logic [2:0] fill, fill2;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;

  logic [12:0] cap_vec[$];
  logic [7:0]  cap_tag[$];
  int          cap_cyc[$];
  logic [1:0]  cap2_tag[$];
  logic [12:0] cap2_vec[$];

  always #5 clk = ~clk;

  pm1_stim_sequencer_if #(.TAG_W(8)) bus ();
  pm1_stim_sequencer_if #(.TAG_W(2)) bus2 ();

  pm1_stim_sequencer #(.DEPTH(4), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .fill(fill)
  );
  pm1_stim_sequencer #(.DEPTH(4), .TAG_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2), .fill(fill2)
  );

  // pm1 stand-in: maps 0x0000 to 0x1BE, every input bit reaches the output.
  function automatic logic [12:0] pm1_model(input logic [15:0] pi);
    return pi[12:0] ^ {10'b0, pi[15:13]} ^ 13'h1BE;
  endfunction

  assign bus.po_bus  = pm1_model(bus.pi_bus);
  assign bus2.po_bus = pm1_model(bus2.pi_bus);

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change #1 after posedge, so negedge sees the handshake that completes next edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      cap_vec.push_back(bus.out_vec);
      cap_tag.push_back(bus.out_tag);
      cap_cyc.push_back(cyc);
    end
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      cap2_vec.push_back(bus2.out_vec);
      cap2_tag.push_back(bus2.out_tag);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_vec.delete(); cap_tag.delete(); cap_cyc.delete();
    cap2_vec.delete(); cap2_tag.delete();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_vec = '0; bus2.out_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_caps();
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k = 0;
    while (cap_vec.size() < n && k < budget) begin tick(); k++; end
    n_cmp++;
    if (cap_vec.size() != n) begin
      n_fail++;
      $display("FAIL wait_caps: got %0d results, required %0d", cap_vec.size(), n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp += 6;
    if (fill !== 3'd0) begin n_fail++; $display("FAIL rst_fill: got %0d required 0", fill); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
    if (bus.pi_bus !== 16'h0) begin n_fail++; $display("FAIL rst_pi_bus: got %h required 0000", bus.pi_bus); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.out_vec !== 13'h0) begin n_fail++; $display("FAIL rst_out_vec: got %h required 0", bus.out_vec); end
    if (bus.out_tag !== 8'h0) begin n_fail++; $display("FAIL rst_out_tag: got %h required 0", bus.out_tag); end
  endtask

  task automatic test_single_beat();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_vec = 16'h0000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp += 2;
    if (fill !== 3'd1) begin n_fail++; $display("FAIL single_fill: got %0d required 1", fill); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early1: out_valid %b required 0", bus.out_valid); end
    tick();
    n_cmp += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_bypass: out_valid %b required 0", bus.out_valid); end
    if (bus.pi_bus !== 16'h0000) begin n_fail++; $display("FAIL single_pi: got %h required 0000", bus.pi_bus); end
    if (fill !== 3'd0) begin n_fail++; $display("FAIL single_fill2: got %0d required 0", fill); end
    tick();
    n_cmp += 3;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b required 1", bus.out_valid); end
    if (bus.out_vec !== 13'h1BE) begin n_fail++; $display("FAIL single_vec: got %h required 1be", bus.out_vec); end
    if (bus.out_tag !== 8'd0) begin n_fail++; $display("FAIL single_tag: got %0d required 0", bus.out_tag); end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: out_valid %b required 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [6] = '{16'h1234, 16'hFFFF, 16'h8001, 16'h00FF, 16'hA5A5, 16'h6000};
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, bus.in_ready); end
      bus.in_valid = 1'b1; bus.in_vec = v[i];
      tick();
    end
    bus.in_valid = 1'b0;
    wait_caps(6, 20);
    for (int i = 0; i < 6 && i < cap_vec.size(); i++) begin
      n_cmp += 3;
      if (cap_tag[i] !== 8'(i)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d required %0d", i, cap_tag[i], i); end
      if (cap_vec[i] !== pm1_model(v[i])) begin n_fail++; $display("FAIL b2b_vec[%0d]: got %h required %h", i, cap_vec[i], pm1_model(v[i])); end
      if (cap_cyc[i] !== cap_cyc[0] + i) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d required %0d", i, cap_cyc[i], cap_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] v [8] = '{16'h0101, 16'h0202, 16'h0404, 16'h0808, 16'h1010, 16'h2020,
                           16'h4040, 16'h8080};
    int n = 0;
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!bus.in_ready) break;
      bus.in_valid = 1'b1; bus.in_vec = v[n]; n++;
      tick();
    end
    bus.in_valid = 1'b0;
    n_cmp += 7;
    if (n !== 6) begin n_fail++; $display("FAIL bp_accepted: got %0d required 6", n); end
    if (fill !== 3'd4) begin n_fail++; $display("FAIL bp_fill: got %0d required 4", fill); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", bus.out_valid); end
    if (bus.out_vec !== pm1_model(v[0])) begin n_fail++; $display("FAIL bp_vec: got %h required %h", bus.out_vec, pm1_model(v[0])); end
    if (bus.out_tag !== 8'd0) begin n_fail++; $display("FAIL bp_tag: got %0d required 0", bus.out_tag); end
    if (bus.pi_bus !== v[1]) begin n_fail++; $display("FAIL bp_pi: got %h required %h", bus.pi_bus, v[1]); end
    repeat (3) tick();
    n_cmp += 3;
    if (bus.pi_bus !== v[1]) begin n_fail++; $display("FAIL bp_pi_hold: got %h required %h", bus.pi_bus, v[1]); end
    if (bus.out_vec !== pm1_model(v[0])) begin n_fail++; $display("FAIL bp_vec_hold: got %h required %h", bus.out_vec, pm1_model(v[0])); end
    if (fill !== 3'd4) begin n_fail++; $display("FAIL bp_fill_hold: got %0d required 4", fill); end
    bus.out_ready = 1'b1;
    wait_caps(6, 30);
    repeat (3) tick();
    n_cmp++;
    if (cap_vec.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d required 6", cap_vec.size()); end
    for (int i = 0; i < 6 && i < cap_vec.size(); i++) begin
      n_cmp += 2;
      if (cap_tag[i] !== 8'(i)) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d required %0d", i, cap_tag[i], i); end
      if (cap_vec[i] !== pm1_model(v[i])) begin n_fail++; $display("FAIL bp_order[%0d]: got %h required %h", i, cap_vec[i], pm1_model(v[i])); end
    end
  endtask

  task automatic test_flush();
    logic [15:0] v [5] = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
    logic [15:0] vx = 16'h5A5A;
    apply_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_vec = v[i];
      tick();
    end
    bus.in_valid = 1'b0;
    n_cmp += 3;
    if (fill !== 3'd3) begin n_fail++; $display("FAIL fl_pre_fill: got %0d required 3", fill); end
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_pre_valid: got %b required 1", bus.out_valid); end
    if (bus.pi_bus !== v[1]) begin n_fail++; $display("FAIL fl_pre_pi: got %h required %h", bus.pi_bus, v[1]); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp += 6;
    if (fill !== 3'd0) begin n_fail++; $display("FAIL fl_fill: got %0d required 0", fill); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_s2_valid: got %b required 1", bus.out_valid); end
    if (bus.out_vec !== pm1_model(v[0])) begin n_fail++; $display("FAIL fl_s2_vec: got %h required %h", bus.out_vec, pm1_model(v[0])); end
    if (bus.out_tag !== 8'd0) begin n_fail++; $display("FAIL fl_s2_tag: got %0d required 0", bus.out_tag); end
    if (bus.pi_bus !== v[1]) begin n_fail++; $display("FAIL fl_pi_kept: got %h required %h", bus.pi_bus, v[1]); end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    n_cmp += 2;
    if (cap_vec.size() !== 1) begin n_fail++; $display("FAIL fl_s1_dropped: got %0d results required 1", cap_vec.size()); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drained: out_valid %b required 0", bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_vec = vx;
    tick();
    bus.in_valid = 1'b0;
    wait_caps(2, 10);
    if (cap_vec.size() >= 2) begin
      n_cmp += 2;
      if (cap_tag[1] !== 8'd1) begin n_fail++; $display("FAIL fl_next_tag: got %0d required 1", cap_tag[1]); end
      if (cap_vec[1] !== pm1_model(vx)) begin n_fail++; $display("FAIL fl_next_vec: got %h required %h", cap_vec[1], pm1_model(vx)); end
    end
  endtask

  task automatic test_tag_wrap();
    logic [1:0]  exp_tag [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] v [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    int k = 0;
    apply_reset();
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_vec = v[i];
      tick();
    end
    bus2.in_valid = 1'b0;
    while (cap2_tag.size() < 5 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (cap2_tag.size() !== 5) begin n_fail++; $display("FAIL wrap_count: got %0d required 5", cap2_tag.size()); end
    for (int i = 0; i < 5 && i < cap2_tag.size(); i++) begin
      n_cmp += 2;
      if (cap2_tag[i] !== exp_tag[i]) begin n_fail++; $display("FAIL wrap_tag[%0d]: got %0d required %0d", i, cap2_tag[i], exp_tag[i]); end
      if (cap2_vec[i] !== pm1_model(v[i])) begin n_fail++; $display("FAIL wrap_vec[%0d]: got %h required %h", i, cap2_vec[i], pm1_model(v[i])); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] vn = 16'h7E57;
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_vec = 16'h0F00 + 16'(i);
      tick();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b required 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_cmp += 6;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b required 0", bus.out_valid); end
    if (fill !== 3'd0) begin n_fail++; $display("FAIL mid_fill: got %0d required 0", fill); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b required 1", bus.in_ready); end
    if (bus.pi_bus !== 16'h0) begin n_fail++; $display("FAIL mid_pi: got %h required 0000", bus.pi_bus); end
    if (bus.out_vec !== 13'h0) begin n_fail++; $display("FAIL mid_vec: got %h required 0", bus.out_vec); end
    if (bus.out_tag !== 8'h0) begin n_fail++; $display("FAIL mid_tag: got %0d required 0", bus.out_tag); end
    tick();
    rst_n = 1'b1;
    tick();
    clear_caps();
    bus.in_valid = 1'b1; bus.in_vec = vn;
    tick();
    bus.in_valid = 1'b0;
    wait_caps(1, 10);
    if (cap_vec.size() >= 1) begin
      n_cmp += 2;
      if (cap_tag[0] !== 8'd0) begin n_fail++; $display("FAIL mid_new_tag: got %0d required 0", cap_tag[0]); end
      if (cap_vec[0] !== pm1_model(vn)) begin n_fail++; $display("FAIL mid_new_vec: got %h required %h", cap_vec[0], pm1_model(vn)); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_tag_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
